// File: rtl/ram_wr_arbiter.sv
// Write-port arbiter sharing one RAM write port between the ADC burst writer and the host.
// ADC bursts lock the port until their last word; ADC writes into address 0 or the ADC register window are dropped.
//
// state     | meaning
// IDLE      | no lock; round-robin between ADC and host
// ADC_BURST | ADC burst in progress; host held off until ADC last word
// HOST      | one-cycle host grant slot, then back to IDLE
module ram_wr_arbiter #(
    parameter int                ADDR_W  = 14,
    parameter int                DATA_W  = 32,
    parameter logic [ADDR_W-1:0] PROT_LO = 14'h3F8,
    parameter logic [ADDR_W-1:0] PROT_HI = 14'h3FC
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              adc_wr_req,
    input  logic [ADDR_W-1:0] adc_wr_addr,
    input  logic [DATA_W-1:0] adc_wr_data,
    input  logic              adc_wr_last,
    output logic              adc_wr_ack,
    input  logic              host_wr_req,
    input  logic [ADDR_W-1:0] host_wr_addr,
    input  logic [DATA_W-1:0] host_wr_data,
    output logic              host_wr_ack,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_wr_en,
    output logic              adc_viol,
    output logic [7:0]        viol_cnt
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ADC_BURST = 2'd1,
        HOST      = 2'd2
    } state_t;

    state_t state;
    logic   last_host;
    logic   adc_elig;
    logic   host_elig;
    logic   adc_prot;
    logic   adc_grant;
    logic   host_grant;

    // A held word whose ack is already high this cycle must not be accepted twice.
    always_comb begin
        adc_elig   = adc_wr_req && !adc_wr_ack;
        host_elig  = host_wr_req && !host_wr_ack;
        adc_prot   = (adc_wr_addr == '0) ||
                     ((adc_wr_addr >= PROT_LO) && (adc_wr_addr <= PROT_HI));
        adc_grant  = adc_elig &&
                     ((state == ADC_BURST) ||
                      ((state == IDLE) && (!host_elig || last_host)));
        host_grant = host_elig && (state == IDLE) && !adc_grant;
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state       <= IDLE;
            last_host   <= 1'b0;
            adc_wr_ack  <= 1'b0;
            host_wr_ack <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            mem_wr_en   <= 1'b0;
            adc_viol    <= 1'b0;
            viol_cnt    <= 8'd0;
        end else begin
            adc_wr_ack  <= 1'b0;
            host_wr_ack <= 1'b0;
            mem_wr_en   <= 1'b0;
            adc_viol    <= 1'b0;
            if (adc_grant) begin
                adc_wr_ack <= 1'b1;
                last_host  <= 1'b0;
                if (adc_prot) begin
                    adc_viol <= 1'b1;
                    if (viol_cnt != 8'hFF) begin
                        viol_cnt <= viol_cnt + 8'd1;
                    end
                end else begin
                    mem_wr_en   <= 1'b1;
                    mem_wr_addr <= adc_wr_addr;
                    mem_wr_data <= adc_wr_data;
                end
                state <= adc_wr_last ? IDLE : ADC_BURST;
            end else if (host_grant) begin
                host_wr_ack <= 1'b1;
                mem_wr_en   <= 1'b1;
                mem_wr_addr <= host_wr_addr;
                mem_wr_data <= host_wr_data;
                state       <= HOST;
            end else if (state == HOST) begin
                state     <= IDLE;
                last_host <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ram_wr_arbiter.sv
// Scoreboard bench for ram_wr_arbiter: expected RAM writes are queued in arbitration order
// and matched against mem_wr_* by a negedge monitor.
module tb_ram_wr_arbiter;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        adc_wr_req = 1'b0;
    logic [13:0] adc_wr_addr = '0;
    logic [31:0] adc_wr_data = '0;
    logic        adc_wr_last = 1'b0;
    logic        adc_wr_ack;
    logic        host_wr_req = 1'b0;
    logic [13:0] host_wr_addr = '0;
    logic [31:0] host_wr_data = '0;
    logic        host_wr_ack;
    logic [13:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        mem_wr_en;
    logic        adc_viol;
    logic [7:0]  viol_cnt;

    ram_wr_arbiter dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .adc_wr_req   (adc_wr_req),
        .adc_wr_addr  (adc_wr_addr),
        .adc_wr_data  (adc_wr_data),
        .adc_wr_last  (adc_wr_last),
        .adc_wr_ack   (adc_wr_ack),
        .host_wr_req  (host_wr_req),
        .host_wr_addr (host_wr_addr),
        .host_wr_data (host_wr_data),
        .host_wr_ack  (host_wr_ack),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_en    (mem_wr_en),
        .adc_viol     (adc_viol),
        .viol_cnt     (viol_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [13:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          adc_acks = 0;
    int          host_acks = 0;
    int          viol_pulses = 0;
    int          host_seen_adc = -1;
    logic        rst_seen = 1'b1;
    logic [13:0] last_addr = '0;
    logic [31:0] last_data = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge sys_clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    // Monitor: pops the scoreboard on every RAM write and checks hold behaviour otherwise.
    always @(negedge sys_clk) begin
        if (rst_seen) begin
            last_addr = '0;
            last_data = '0;
        end else begin
            chk("dual_ack", 64'(adc_wr_ack & host_wr_ack), 64'(0));
            if (adc_wr_ack) adc_acks++;
            if (host_wr_ack) begin
                host_acks++;
                host_seen_adc = adc_acks;
            end
            if (adc_viol) viol_pulses++;
            if (mem_wr_en) begin
                chk("wr_expected", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", 64'(mem_wr_addr), 64'(e.addr));
                    chk("wr_data", 64'(mem_wr_data), 64'(e.data));
                    last_addr = e.addr;
                    last_data = e.data;
                end
            end else begin
                chk("hold_addr", 64'(mem_wr_addr), 64'(last_addr));
                chk("hold_data", 64'(mem_wr_data), 64'(last_data));
            end
        end
    end

    task automatic push_wr(input logic [13:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_addr"}, 64'(mem_wr_addr), 64'(0));
        chk({tag, "_data"}, 64'(mem_wr_data), 64'(0));
        chk({tag, "_en"}, 64'(mem_wr_en), 64'(0));
        chk({tag, "_adc_ack"}, 64'(adc_wr_ack), 64'(0));
        chk({tag, "_host_ack"}, 64'(host_wr_ack), 64'(0));
        chk({tag, "_viol"}, 64'(adc_viol), 64'(0));
        chk({tag, "_viol_cnt"}, 64'(viol_cnt), 64'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        adc_wr_req = 1'b0;
        host_wr_req = 1'b0;
        repeat (2) @(negedge sys_clk);
        chk_zero_outputs("rst");
        exp_q.delete();
        adc_acks = 0;
        host_acks = 0;
        viol_pulses = 0;
        host_seen_adc = -1;
        rst = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic adc_send(input logic [13:0] a, input logic [31:0] d, input logic last);
        logic ok;
        ok = 1'b0;
        adc_wr_req  = 1'b1;
        adc_wr_addr = a;
        adc_wr_data = d;
        adc_wr_last = last;
        for (int i = 0; i < 60; i++) begin
            @(negedge sys_clk);
            if (adc_wr_ack) begin
                ok = 1'b1;
                break;
            end
        end
        chk("adc_ack_seen", 64'(ok), 64'(1));
        adc_wr_req = 1'b0;
    endtask

    task automatic host_send(input logic [13:0] a, input logic [31:0] d);
        logic ok;
        ok = 1'b0;
        host_wr_req  = 1'b1;
        host_wr_addr = a;
        host_wr_data = d;
        for (int i = 0; i < 60; i++) begin
            @(negedge sys_clk);
            if (host_wr_ack) begin
                ok = 1'b1;
                break;
            end
        end
        chk("host_ack_seen", 64'(ok), 64'(1));
        host_wr_req = 1'b0;
    endtask

    task automatic settle_and_check(input string tag);
        repeat (4) @(negedge sys_clk);
        chk({tag, "_q_empty"}, 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int c1;

        // Plain ADC burst, 2 cycles per word.
        do_reset();
        for (int i = 0; i < 4; i++) push_wr(14'(i + 1), 32'(32'hA0 + i));
        c0 = cyc;
        for (int i = 0; i < 4; i++) adc_send(14'(i + 1), 32'(32'hA0 + i), (i == 3));
        c1 = cyc;
        chk("burst_edges", 64'(c1 - c0), 64'(7));
        settle_and_check("burst");
        chk("burst_adc_acks", 64'(adc_acks), 64'(4));
        chk("burst_viol", 64'(viol_pulses), 64'(0));
        chk("burst_host_acks", 64'(host_acks), 64'(0));

        // Host and ADC burst start together from reset: host wins the first tie.
        do_reset();
        push_wr(14'h0, 32'h5);
        for (int i = 0; i < 4; i++) push_wr(14'(16 + i), 32'(32'hB0 + i));
        fork
            host_send(14'h0, 32'h5);
            for (int i = 0; i < 4; i++) adc_send(14'(16 + i), 32'(32'hB0 + i), (i == 3));
        join
        settle_and_check("tie");
        chk("tie_host_before_adc", 64'(host_seen_adc), 64'(0));
        chk("tie_adc_acks", 64'(adc_acks), 64'(4));
        chk("tie_host_acks", 64'(host_acks), 64'(1));

        // Host raised during an ADC burst waits for the last word.
        do_reset();
        for (int i = 0; i < 4; i++) push_wr(14'(32 + i), 32'(32'hC0 + i));
        push_wr(14'h123, 32'hDEAD);
        fork
            for (int i = 0; i < 4; i++) adc_send(14'(32 + i), 32'(32'hC0 + i), (i == 3));
            begin
                logic seen;
                seen = 1'b0;
                for (int i = 0; i < 60; i++) begin
                    @(negedge sys_clk);
                    if (adc_wr_ack) begin
                        seen = 1'b1;
                        break;
                    end
                end
                chk("lock_first_ack", 64'(seen), 64'(1));
                host_send(14'h123, 32'hDEAD);
            end
        join
        settle_and_check("lock");
        chk("lock_host_after_last", 64'(host_seen_adc), 64'(4));

        // Address protection, including window edges and address 0; host unrestricted.
        do_reset();
        push_wr(14'h3F7, 32'h1);
        push_wr(14'h3FD, 32'h5);
        push_wr(14'h3FA, 32'h77);
        push_wr(14'h000, 32'h88);
        adc_send(14'h3F7, 32'h1, 1'b0);
        adc_send(14'h3F8, 32'h2, 1'b0);
        adc_send(14'h3FA, 32'h3, 1'b0);
        adc_send(14'h3FC, 32'h4, 1'b0);
        adc_send(14'h3FD, 32'h5, 1'b0);
        adc_send(14'h000, 32'h6, 1'b1);
        host_send(14'h3FA, 32'h77);
        host_send(14'h000, 32'h88);
        settle_and_check("prot");
        chk("prot_viol_pulses", 64'(viol_pulses), 64'(4));
        chk("prot_viol_cnt", 64'(viol_cnt), 64'(4));
        chk("prot_adc_acks", 64'(adc_acks), 64'(6));
        chk("prot_host_acks", 64'(host_acks), 64'(2));

        // Violation counter saturation.
        do_reset();
        for (int i = 0; i < 300; i++) adc_send(14'h3F9, 32'(i), 1'b1);
        settle_and_check("sat");
        chk("sat_viol_pulses", 64'(viol_pulses), 64'(300));
        chk("sat_viol_cnt", 64'(viol_cnt), 64'(255));

        // Reset mid-burst abandons the lock; host and ADC tie afterwards goes to host.
        do_reset();
        push_wr(14'h101, 32'h1);
        push_wr(14'h102, 32'h2);
        adc_send(14'h101, 32'h1, 1'b0);
        adc_send(14'h102, 32'h2, 1'b0);
        rst          = 1'b1;
        host_wr_req  = 1'b1;
        host_wr_addr = 14'h55;
        host_wr_data = 32'hBEEF;
        adc_wr_req   = 1'b1;
        adc_wr_addr  = 14'h103;
        adc_wr_data  = 32'h3;
        adc_wr_last  = 1'b1;
        @(negedge sys_clk);
        chk_zero_outputs("midrst");
        chk("midrst_q_empty", 64'(exp_q.size()), 64'(0));
        push_wr(14'h55, 32'hBEEF);
        push_wr(14'h103, 32'h3);
        rst = 1'b0;
        @(negedge sys_clk);
        chk("postrst_host_ack", 64'(host_wr_ack), 64'(1));
        chk("postrst_adc_ack", 64'(adc_wr_ack), 64'(0));
        host_wr_req = 1'b0;
        begin
            logic ok;
            ok = 1'b0;
            for (int i = 0; i < 60; i++) begin
                @(negedge sys_clk);
                if (adc_wr_ack) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk("postrst_adc_granted", 64'(ok), 64'(1));
            adc_wr_req = 1'b0;
        end
        settle_and_check("postrst");
        chk("postrst_viol_cnt", 64'(viol_cnt), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ram_wr_arbiter.md
RAM_WR_ARBITER -- requirements
Module: ram_wr_arbiter

Interface
REQ-001 Clock and reset SHALL be one clock; reset is synchronous and active-high.
REQ-002 Parameter ADDR_W, 14: RAM write address width.
REQ-003 Parameter DATA_W, 32: RAM write data width.
REQ-004 Parameter PROT_LO, 14'h3F8: first address of the ADC register window.
REQ-005 Parameter PROT_HI, 14'h3FC: last address of the ADC register window.
REQ-006 sys_clk  in  1  system clock; all logic on rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 adc_wr_req  in  1  ADC writer requests one word write; held with addr/data until acked.
REQ-009 adc_wr_addr  in  ADDR_W  ADC word address.
REQ-010 adc_wr_data  in  DATA_W  ADC word data.
REQ-011 adc_wr_last  in  1  marks final word of an ADC burst; valid with adc_wr_req.
REQ-012 adc_wr_ack  out  1  one-cycle pulse: ADC word consumed.
REQ-013 host_wr_req / host_wr_addr / host_wr_data  in  1 / ADDR_W / DATA_W  host (DSMC) single-word write request and payload, held until acked.
REQ-014 host_wr_ack  out  1  one-cycle pulse: host word consumed.
REQ-015 mem_wr_addr / mem_wr_data / mem_wr_en  out  ADDR_W / DATA_W / 1  shared RAM write port, registered.
REQ-016 adc_viol  out  1  one-cycle pulse: ADC word dropped by address protection.
REQ-017 viol_cnt  out  8  saturating count of dropped ADC words.

Function
REQ-018 FSM states SHALL be IDLE, ADC_BURST, HOST; state, ack and mem_wr_* outputs registered.
REQ-019 A requester SHALL be eligible when its req=1 and its ack was 0 in the current cycle (no double accept of a held word).
REQ-020 Grant for req sampled at edge N SHALL appear at edge N+1: ack=1, mem_wr_en=1 (unless dropped), mem_wr_addr/data = granted payload; latency 1 cycle.
REQ-021 At most one ack SHALL be high per cycle; adc_wr_ack and host_wr_ack never both 1.
REQ-022 IDLE: only ADC eligible -> grant ADC; if not last go ADC_BURST else stay IDLE. Only host eligible -> grant host, go HOST.
REQ-023 IDLE, both eligible: grant the requester not granted most recently (round-robin flag last_host, reset 0 so host wins first tie).
REQ-024 ADC_BURST: host SHALL NOT be granted; ADC words granted as eligible; word with adc_wr_last=1 ends lock -> IDLE, last_host=0.
REQ-025 HOST: lasts exactly one cycle (host is single-word) -> IDLE, last_host=1.
REQ-026 ADC word with addr==0 or PROT_LO<=addr<=PROT_HI SHALL be acked with mem_wr_en=0, adc_viol=1, viol_cnt+1 (saturate at 255); adc_wr_last still honoured.
REQ-027 Host writes SHALL be unrestricted, including address 0 and the protected window.
REQ-028 When no grant occurs, mem_wr_en SHALL be 0 and mem_wr_addr/data SHALL hold last values.
REQ-029 ADC 4-word burst at 2 cycles/word (req, ack, req, ...) SHALL complete with 4 writes in 8 cycles and no host interleave.
REQ-030 Requester dropping req without ack SHALL be tolerated: no ack issued, lock (ADC_BURST) retained until a last word is acked.

Reset
REQ-031 With rst=1 at an edge: state=IDLE, last_host=0, mem_wr_addr=0, mem_wr_data=0, mem_wr_en=0, both acks=0, adc_viol=0, viol_cnt=0.
REQ-032 Reset mid-burst SHALL abandon the lock; first post-reset cycle with both req high grants host.

Verification
REQ-033 ADC burst addr 1..4, data 0xA0..0xA3, last on 4th, host idle -> four mem_wr_en pulses at 1..4 with those data, 4 adc_wr_ack, no viol.
REQ-034 Host req addr 0 data 0x5 concurrent with ADC burst start, both from reset -> host written first at addr 0, then ADC 4 words; no host ack during ADC_BURST.
REQ-035 Host req raised after ADC word 1 acked -> host_wr_ack only after ADC word 4 (last) acked, next eligible cycle.
REQ-036 ADC word addr 0x3FA and addr 0 -> acked, mem_wr_en=0, adc_viol pulses, viol_cnt=2; host write to 0x3FA -> mem_wr_en=1.
REQ-037 300 protected ADC words -> viol_cnt stops at 255.
REQ-038 rst asserted after ADC word 2 -> all outputs zero next cycle; pending host then granted immediately after rst release.
